// File: rtl/mic_note_filter_if.sv
// Bundles the mic_note_filter frame input and filtered-note output signals.
// The master side drives detector frames; the slave side is the filter.
`timescale 1ns/1ps
interface mic_note_filter_if;
  logic        raw_valid;
  logic [6:0]  raw_note;
  logic [11:0] raw_level;
  logic [6:0]  mic_note;
  logic        note_stable;
  logic        note_change;

  modport master (
    output raw_valid, raw_note, raw_level,
    input  mic_note, note_stable, note_change
  );

  modport slave (
    input  raw_valid, raw_note, raw_level,
    output mic_note, note_stable, note_change
  );
endinterface

// File: rtl/mic_note_filter.sv
// mic_note_filter: debounces and hysteretically filters raw pitch-detector
// frames into a 7-bit note code (0 = silence). Quiet or reserved frames read
// as silence, and a long gap between frames forces silence.
// Optional macro MIC_NOTE_FILTER_SEMITONE_TOL_EN: while a note is held, a
// frame within +/-1 of it counts as the same note.
`timescale 1ns/1ps
module mic_note_filter #(
  parameter int          CONFIRM_COUNT  = 4,
  parameter int          RELEASE_COUNT  = 3,
  parameter logic [11:0] LEVEL_THRESH   = 12'd200,
  parameter int          TIMEOUT_CYCLES = 5_000_000
) (
  input  logic            clk_in,
  input  logic            rst_in,
  mic_note_filter_if.slave bus
);

  localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      CONF     = 4'(CONFIRM_COUNT);
  localparam logic [3:0]      REL      = 4'(RELEASE_COUNT);

  typedef enum logic [1:0] {SILENT, CANDIDATE, LOCKED, RELEASE} state_t;

  state_t        state_q;
  logic [6:0]    mic_q, cand_q;
  logic [3:0]    cnt_q;
  logic [TW-1:0] tmo_q;
  logic          stable_q, change_q;

  logic [6:0]    eff;
  logic [3:0]    cnt_inc;
  logic [TW-1:0] tmo_inc;
  logic          near_mic, do_commit;
  logic [6:0]    commit_val;

  // Frame qualification, saturating match count and the held-note compare.
  always_comb begin
    eff = 7'd0;
    if (bus.raw_level >= LEVEL_THRESH && bus.raw_note != 7'd0 && bus.raw_note <= 7'd123)
      eff = bus.raw_note;
    cnt_inc = (cnt_q == 4'hF) ? 4'hF : cnt_q + 4'd1;
    tmo_inc = tmo_q + TW'(1);
`ifdef MIC_NOTE_FILTER_SEMITONE_TOL_EN
    near_mic = (mic_q != 7'd0) && (eff != 7'd0) &&
               ((eff == mic_q) ||
                ({1'b0, eff} == {1'b0, mic_q} + 8'd1) ||
                ({1'b0, eff} + 8'd1 == {1'b0, mic_q}));
`else
    near_mic = (eff == mic_q);
`endif
    // Leaving a held note: either the first differing frame (RELEASE_COUNT=1)
    // or the frame completing a run of identical differing frames.
    commit_val = (state_q == LOCKED) ? eff : cand_q;
    do_commit  = bus.raw_valid && !near_mic &&
                 (((state_q == LOCKED) && (REL == 4'd1)) ||
                  ((state_q == RELEASE) && (eff == cand_q) && (cnt_inc == REL)));
  end

  // Filter state machine with registered outputs and the frame-gap timeout.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= SILENT;
      mic_q    <= 7'd0;
      cand_q   <= 7'd0;
      cnt_q    <= 4'd0;
      tmo_q    <= '0;
      stable_q <= 1'b0;
      change_q <= 1'b0;
    end else begin
      change_q <= 1'b0;
      if (bus.raw_valid) begin
        tmo_q <= '0;
        if (do_commit) begin
          mic_q    <= commit_val;
          change_q <= (commit_val != mic_q);
          cand_q   <= commit_val;
          if (commit_val == 7'd0) begin
            state_q  <= SILENT;
            stable_q <= 1'b0;
            cnt_q    <= 4'd0;
          end else begin
            state_q  <= LOCKED;
            stable_q <= 1'b1;
            cnt_q    <= cnt_inc;
          end
        end else begin
          case (state_q)
            SILENT: begin
              if (eff != 7'd0) begin
                cand_q <= eff;
                cnt_q  <= 4'd1;
                if (CONF == 4'd1) begin
                  state_q  <= LOCKED;
                  mic_q    <= eff;
                  change_q <= (eff != mic_q);
                  stable_q <= 1'b1;
                end else begin
                  state_q <= CANDIDATE;
                end
              end
            end
            CANDIDATE: begin
              if (eff == 7'd0) begin
                state_q <= SILENT;
                cnt_q   <= 4'd0;
              end else if (eff == cand_q) begin
                cnt_q <= cnt_inc;
                if (cnt_inc == CONF) begin
                  state_q  <= LOCKED;
                  mic_q    <= cand_q;
                  change_q <= (cand_q != mic_q);
                  stable_q <= 1'b1;
                end
              end else begin
                cand_q <= eff;
                cnt_q  <= 4'd1;
              end
            end
            LOCKED: begin
              if (!near_mic) begin
                state_q  <= RELEASE;
                stable_q <= 1'b0;
                cand_q   <= eff;
                cnt_q    <= 4'd1;
              end
            end
            RELEASE: begin
              if (near_mic) begin
                state_q  <= LOCKED;
                stable_q <= 1'b1;
              end else if (eff == cand_q) begin
                cnt_q <= cnt_inc;
              end else begin
                cand_q <= eff;
                cnt_q  <= 4'd1;
              end
            end
            default: state_q <= SILENT;
          endcase
        end
      end else if (tmo_inc == TMO_LAST) begin
        // Detector went quiet: drop to silence, pulsing only if a note was out.
        tmo_q    <= '0;
        state_q  <= SILENT;
        cnt_q    <= 4'd0;
        stable_q <= 1'b0;
        if (mic_q != 7'd0) begin
          mic_q    <= 7'd0;
          change_q <= 1'b1;
        end
      end else begin
        tmo_q <= tmo_inc;
      end
    end
  end

  assign bus.mic_note    = mic_q;
  assign bus.note_stable = stable_q;
  assign bus.note_change = change_q;

endmodule
